// File: rtl/rice_core_pipeline_buffer.sv
// Elastic buffer between two rice core pipeline stages, holding up to DEPTH results in FIFO order.
// Latency: one cycle; an entry pushed at edge N appears on o_data after edge N, with no same-cycle bypass.
// Backpressure: o_ready is low only when all DEPTH entries are full, and it comes from registered count alone.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge) and asynchronous active-low reset
//   i_flush             drop every held entry; this wins over a push or pop in the same cycle
//   i_valid/o_ready     upstream handshake, carrying i_data  [WIDTH-1:0]
//   o_valid/i_ready     downstream handshake, carrying o_data [WIDTH-1:0] (the head entry)
//   o_count             number of held entries, 0..DEPTH
module rice_core_pipeline_buffer #(
    parameter int WIDTH       = 64,
    parameter int DEPTH       = 2,
    parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [WIDTH-1:0]       i_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [WIDTH-1:0]       o_data,
    output logic [COUNT_WIDTH-1:0] o_count
);

    // A one-entry buffer still needs a one-bit pointer. That pointer stays at zero.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]       PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_FULL = COUNT_WIDTH'(DEPTH);

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [COUNT_WIDTH-1:0] count;
    logic                   push;
    logic                   pop;

    // The pointer wraps explicitly, so a DEPTH that is not a power of two also works.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_ready = (count != CNT_FULL);
    assign o_valid = (count != '0);
    assign o_data  = mem[rd_ptr];
    assign o_count = count;

    assign push = i_valid && o_ready;
    assign pop  = o_valid && i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_flush) begin
            // Flush resets the pointers and the count only. Stale payloads stay in storage
            // but cannot be seen, because o_valid is low.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= i_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_WIDTH'(1);
                2'b01:   count <= count - COUNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    // Upstream must hold a refused result steady. The only exception is that a flush
    // may withdraw it.
    a_upstream_hold : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (i_valid && !o_ready && !i_flush) |=> (i_flush || (i_valid && $stable(i_data))));

endmodule

// File: tb/tb_rice_core_pipeline_buffer.sv
module tb_rice_core_pipeline_buffer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance a: DEPTH=2, WIDTH=64
    logic        a_flush, a_vld, a_ordy, a_ovld, a_irdy;
    logic [63:0] a_dat, a_odat;
    logic [1:0]  a_cnt;
    // Instance b: DEPTH=3, WIDTH=8
    logic        b_flush, b_vld, b_ordy, b_ovld, b_irdy;
    logic [7:0]  b_dat, b_odat;
    logic [1:0]  b_cnt;
    // Instance c: DEPTH=1, WIDTH=8
    logic        c_flush, c_vld, c_ordy, c_ovld, c_irdy;
    logic [7:0]  c_dat, c_odat;
    logic [0:0]  c_cnt;

    rice_core_pipeline_buffer #(.WIDTH(64), .DEPTH(2)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(a_flush), .i_valid(a_vld), .o_ready(a_ordy),
        .i_data(a_dat), .o_valid(a_ovld), .i_ready(a_irdy), .o_data(a_odat), .o_count(a_cnt));
    rice_core_pipeline_buffer #(.WIDTH(8), .DEPTH(3)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(b_flush), .i_valid(b_vld), .o_ready(b_ordy),
        .i_data(b_dat), .o_valid(b_ovld), .i_ready(b_irdy), .o_data(b_odat), .o_count(b_cnt));
    rice_core_pipeline_buffer #(.WIDTH(8), .DEPTH(1)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(c_flush), .i_valid(c_vld), .o_ready(c_ordy),
        .i_data(c_dat), .o_valid(c_ovld), .i_ready(c_irdy), .o_data(c_odat), .o_count(c_cnt));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just past the next rising edge. Checks and input changes happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_rdy;
        int   k;

        {a_flush, a_vld, a_irdy, a_dat} = '0;
        {b_flush, b_vld, b_irdy, b_dat} = '0;
        {c_flush, c_vld, c_irdy, c_dat} = '0;

        // Reset state
        #2;
        chk("rst_a_vld", a_ovld, 0);
        chk("rst_a_rdy", a_ordy, 1);
        chk("rst_a_cnt", a_cnt, 0);
        chk("rst_a_dat", a_odat, 0);
        chk("rst_b_rdy", b_ordy, 1);
        chk("rst_c_rdy", c_ordy, 1);
        #10 rst_n = 1'b1;
        tick();

        // Streaming, DEPTH=2: one result per cycle, count stays at 1
        chk("str_cnt0", a_cnt, 0);
        a_irdy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a_vld = 1'b1;
            a_dat = 64'(i);
            chk("str_rdy", a_ordy, 1);
            tick();
            chk("str_vld", a_ovld, 1);
            chk("str_dat", a_odat, 64'(i));
            chk("str_cnt", a_cnt, 1);
        end
        a_vld = 1'b0;
        tick();
        chk("str_drain", a_ovld, 0);

        // Asynchronous reset mid-cycle with 2 entries held
        a_irdy = 1'b0;
        a_vld = 1'b1; a_dat = 64'h1; tick();
        a_dat = 64'h2; tick();
        a_vld = 1'b0;
        chk("ar_cnt_pre", a_cnt, 2);
        chk("ar_rdy_pre", a_ordy, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_vld", a_ovld, 0);
        chk("ar_rdy", a_ordy, 1);
        chk("ar_cnt", a_cnt, 0);
        chk("ar_dat", a_odat, 0);
        #2 rst_n = 1'b1;
        tick();
        chk("ar_empty", a_ovld, 0);
        a_vld = 1'b1; a_dat = 64'hA5;
        tick();
        a_vld = 1'b0;
        chk("ar_push_vld", a_ovld, 1);
        chk("ar_push_dat", a_odat, 64'hA5);
        a_irdy = 1'b1;
        tick();
        chk("ar_drain", a_ovld, 0);

        // Backpressure and full, DEPTH=3, with both pointers wrapping
        b_irdy = 1'b0;
        b_vld = 1'b1;
        b_dat = 8'h11; tick();
        b_dat = 8'h22; tick();
        b_dat = 8'h33; tick();
        b_dat = 8'h44;
        chk("bp_cnt_full", b_cnt, 3);
        chk("bp_rdy_full", b_ordy, 0);
        chk("bp_head", b_odat, 8'h11);
        tick();
        chk("bp_hold_cnt", b_cnt, 3);
        chk("bp_hold_dat", b_odat, 8'h11);
        b_irdy = 1'b1;
        tick();
        chk("bp_pop1_cnt", b_cnt, 2);
        chk("bp_pop1_dat", b_odat, 8'h22);
        chk("bp_pop1_rdy", b_ordy, 1);
        tick();
        b_vld = 1'b0;
        chk("bp_pop2_cnt", b_cnt, 2);
        chk("bp_pop2_dat", b_odat, 8'h33);
        tick();
        chk("bp_pop3_cnt", b_cnt, 1);
        chk("bp_pop3_dat", b_odat, 8'h44);
        tick();
        chk("bp_empty", b_ovld, 0);
        chk("bp_cnt0", b_cnt, 0);

        // Push and pop together while full, DEPTH=2: the pop goes ahead and the push waits
        a_irdy = 1'b0;
        a_vld = 1'b1; a_dat = 64'h10; tick();
        a_dat = 64'h20; tick();
        a_dat = 64'h30; a_irdy = 1'b1;
        chk("fp_rdy_full", a_ordy, 0);
        tick();
        chk("fp_cnt1", a_cnt, 1);
        chk("fp_dat1", a_odat, 64'h20);
        a_irdy = 1'b0;
        tick();
        a_vld = 1'b0;
        chk("fp_cnt2", a_cnt, 2);
        chk("fp_dat2", a_odat, 64'h20);
        a_irdy = 1'b1;
        tick();
        chk("fp_dat3", a_odat, 64'h30);
        tick();
        chk("fp_empty", a_ovld, 0);

        // A flush beats a simultaneous push and pop
        a_irdy = 1'b0;
        a_vld = 1'b1; a_dat = 64'h41; tick();
        a_dat = 64'h42; tick();
        chk("fl_cnt_pre", a_cnt, 2);
        a_flush = 1'b1; a_dat = 64'h55; a_irdy = 1'b1;
        tick();
        a_flush = 1'b0;
        chk("fl_vld", a_ovld, 0);
        chk("fl_cnt", a_cnt, 0);
        chk("fl_rdy", a_ordy, 1);
        a_dat = 64'h66; a_irdy = 1'b0;
        tick();
        a_vld = 1'b0;
        chk("fl_next_vld", a_ovld, 1);
        chk("fl_next_dat", a_odat, 64'h66);
        chk("fl_next_cnt", a_cnt, 1);
        a_irdy = 1'b1;
        tick();
        chk("fl_drain", a_ovld, 0);

        // DEPTH=1: accepts every other cycle, so o_ready alternates
        exp_rdy = 1'b1;
        k = 0;
        c_irdy = 1'b1;
        c_vld = 1'b1;
        c_dat = 8'hC0;
        for (int i = 0; i < 8; i++) begin
            chk("d1_rdy", c_ordy, exp_rdy);
            tick();
            if (exp_rdy) begin
                chk("d1_vld", c_ovld, 1);
                chk("d1_dat", c_odat, 64'(8'hC0 + k));
                k++;
                c_dat = 8'(8'hC0 + k);
            end else begin
                chk("d1_gap", c_ovld, 0);
            end
            exp_rdy = !exp_rdy;
        end
        c_vld = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rice_core_pipeline_buffer.md
# rice_core_pipeline_buffer

Parametrised elastic buffer placed between two rice core pipeline stages (IF→ID, ID→EX), replacing the single-entry stage register. It carries one stage result per entry under a valid/ready handshake instead of a global stall signal, holds up to DEPTH results, and discards all of them on flush. Payload is opaque: the instantiating stage packs its result structure into WIDTH bits.

## Interface
Parameters:
- WIDTH, 64, payload width in bits (≥1)
- DEPTH, 2, number of entries (≥1; non-power-of-two allowed)
- COUNT_WIDTH, $clog2(DEPTH+1), width of o_count (derived; do not override)

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_flush  input  1  discard all entries this cycle
- i_valid  input  1  upstream has a result on i_data
- o_ready  output  1  buffer can accept a result
- i_data  input  WIDTH  upstream result
- o_valid  output  1  head entry available on o_data
- i_ready  input  1  downstream accepts head (replaces !stall)
- o_data  output  WIDTH  head entry payload
- o_count  output  COUNT_WIDTH  number of valid entries

## Operation
- Circular storage of DEPTH entries, write pointer, read pointer, entry count; pointers wrap from DEPTH-1 to 0.
- push = i_valid && o_ready; pop = o_valid && i_ready.
- o_ready = (count != DEPTH); depends on registered state only, no combinational path from i_ready or i_valid.
- o_valid = (count != 0); o_data = storage[read pointer] (registered storage, mux on read pointer).
- push and pop in same cycle: both take effect, count unchanged. Allowed when full only for the pop; push is blocked when full because o_ready is low.
- Flush: i_flush high → next cycle count = 0, read pointer = write pointer = 0, o_valid = 0, o_ready = 1. Any push or pop in the flush cycle is ignored (flush wins). Storage contents are not cleared.
- Ordering: strict FIFO; no entry reordered, duplicated or dropped except by flush.
- Upstream protocol (checked by assertions, not enforced): i_valid and i_data held stable until accepted, except that i_valid may drop on a cycle where i_flush is high.
- Downstream sees o_valid/o_data stable while o_valid && !i_ready && !i_flush.

## Timing
- Reset (i_rst_n low, asynchronous): count 0, pointers 0, storage all zero; o_valid 0, o_ready 1, o_data 0, o_count 0. Outputs take these values immediately on assertion, regardless of clock.
- Reset deassertion mid-traffic: first edge after release behaves as empty buffer; data pushed before reset is lost.
- Latency: push at edge N → o_valid high after edge N (visible cycle N+1) when buffer was empty; no same-cycle bypass.
- Throughput: DEPTH ≥ 2 sustains one result per cycle with i_ready held high; DEPTH = 1 sustains one result per two cycles (o_ready low while the entry is held).
- o_ready falls the cycle after the push that fills the last entry; rises the cycle after the pop that frees one.
- o_count updates the cycle after the push/pop/flush causing it; range 0..DEPTH.
- Flush and reset share no path; flush is synchronous only.

## Test plan
- Reset: assert i_rst_n low mid-cycle with 2 entries held → o_valid 0, o_ready 1, o_count 0, o_data 0 immediately; after release, push 0xA5 → o_data 0xA5, o_valid 1 one cycle later.
- Streaming, DEPTH=2, WIDTH=64: push 0..99 back-to-back with i_ready=1 → o_data 0..99 in order, one per cycle, o_ready never low, o_count ≤1.
- Backpressure/full, DEPTH=3: i_ready=0, push 0x11,0x22,0x33,0x44 → o_count 3, o_ready 0, 0x44 held upstream; raise i_ready → outputs 0x11,0x22,0x33,0x44 in order, wrap-around exercised on both pointers.
- Simultaneous push+pop when full, DEPTH=2: hold full, i_ready=1 with i_valid=1 → pop occurs, push blocked that cycle; next cycle push accepted, count returns to 2.
- Flush priority: buffer holding 2 entries, same cycle i_flush=1, i_valid=1 (0x55), i_ready=1 → next cycle o_valid 0, o_count 0, o_ready 1; 0x55 never appears on o_data; following push 0x66 emerges next.
- DEPTH=1: continuous i_valid and i_ready → acceptance every other cycle, o_ready toggles 1,0,1,0; data order preserved.
